// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: request/ack instruction fetcher with a {pc,inst} prefetch FIFO.
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic {FETCH, DRAIN} state_t;
  state_t state, state_nxt;
  logic [31:0] fetch_pc, drain_addr;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic pending, ack, stall, push, pop;
  assign ack        = mem_req & mem_ack;
  assign stall      = mem_req & ~mem_ack;
  assign push       = ack & ~redirect & (state == FETCH);
  assign pop        = inst_valid & inst_ready;
  assign inst_valid = count != '0;
  assign inst       = inst_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];
  always_ff @(posedge clk)
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  // A stalled request cannot be withdrawn, so a redirect during it waits out the stale ack.
  always_comb
    state_nxt = redirect ? (stall ? DRAIN : FETCH) : (state == DRAIN && ack) ? FETCH : state;
  always_comb begin
    mem_req  = ~reset & ((state == DRAIN) | pending | (count < FULL));
    mem_addr = (state == DRAIN) ? drain_addr : fetch_pc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      drain_addr   <= RESET_PC;
      pending      <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else begin
      pending      <= stall;
      misalign_err <= misalign_err | (redirect & |redirect_pc[1:0]);
      if (redirect) begin
        fetch_pc   <= {redirect_pc[31:2], 2'b00};
        drain_addr <= mem_addr;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr]   <= fetch_pc;
          inst_mem[wr_ptr] <= mem_rdata;
          wr_ptr           <= wr_ptr + 1'b1;
          fetch_pc         <= fetch_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed vector table plus randomized run against a queue-based fetch model.
module tb_fetch_prefetch_unit;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset, mem_req, mem_ack, inst_valid, inst_ready, redirect, misalign_err;
  logic [31:0] mem_addr, mem_rdata, inst, inst_pc, redirect_pc;
  int checks = 0, failures = 0;
  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  in;
    logic [31:0] rpc;
    logic [3:0]  out;
    logic [31:0] addr;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl [24];
  function automatic logic [31:0] f(input logic [31:0] a);
    return a * 32'd3 + 32'h1357_0000;
  endfunction
  function automatic vec_t v(input logic [3:0] i, input logic [31:0] r, input logic [3:0] o,
                             input logic [31:0] a, input logic [31:0] p);
    vec_t t;
    t.in = i; t.rpc = r; t.out = o; t.addr = a; t.pc = p;
    return t;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  logic [31:0] q [$];
  logic [31:0] next_fetch, stale_addr, tgt, exp_addr;
  logic stale, prev_pend, miss, exp_req, a, r, d;
  int rb, ab;
  initial begin
    // in = {reset, ack, ready, redirect}; out = {req, valid, err, check pc/inst}
    tbl[0]  = v(4'b0110, 32'h0,        4'b1001, 32'h0,        32'h0);
    tbl[1]  = v(4'b0110, 32'h0,        4'b1101, 32'h4,        32'h0);
    tbl[2]  = v(4'b0000, 32'h0,        4'b1101, 32'h8,        32'h4);
    tbl[3]  = v(4'b0100, 32'h0,        4'b1101, 32'h8,        32'h4);
    tbl[4]  = v(4'b0100, 32'h0,        4'b1101, 32'hC,        32'h4);
    tbl[5]  = v(4'b0100, 32'h0,        4'b1101, 32'h10,       32'h4);
    tbl[6]  = v(4'b0000, 32'h0,        4'b0101, 32'h14,       32'h4);
    tbl[7]  = v(4'b0010, 32'h0,        4'b0101, 32'h14,       32'h4);
    tbl[8]  = v(4'b0000, 32'h0,        4'b1101, 32'h14,       32'h8);
    tbl[9]  = v(4'b0011, 32'h102,      4'b1101, 32'h14,       32'h8);
    tbl[10] = v(4'b0010, 32'h0,        4'b1010, 32'h14,       32'h0);
    tbl[11] = v(4'b0100, 32'h0,        4'b1010, 32'h14,       32'h0);
    tbl[12] = v(4'b0110, 32'h0,        4'b1010, 32'h100,      32'h0);
    tbl[13] = v(4'b0111, 32'hFFFF_FFF8, 4'b1111, 32'h104,     32'h100);
    tbl[14] = v(4'b0100, 32'h0,        4'b1010, 32'hFFFF_FFF8, 32'h0);
    tbl[15] = v(4'b0100, 32'h0,        4'b1111, 32'hFFFF_FFFC, 32'hFFFF_FFF8);
    tbl[16] = v(4'b0010, 32'h0,        4'b1111, 32'h0,        32'hFFFF_FFF8);
    tbl[17] = v(4'b0010, 32'h0,        4'b1111, 32'h0,        32'hFFFF_FFFC);
    tbl[18] = v(4'b0100, 32'h0,        4'b1010, 32'h0,        32'h0);
    tbl[19] = v(4'b0001, 32'h40,       4'b1111, 32'h4,        32'h0);
    tbl[20] = v(4'b1000, 32'h0,        4'b0010, 32'h4,        32'h0);
    tbl[21] = v(4'b0000, 32'h0,        4'b1001, 32'h0,        32'h0);
    tbl[22] = v(4'b0110, 32'h0,        4'b1001, 32'h0,        32'h0);
    tbl[23] = v(4'b0000, 32'h0,        4'b1101, 32'h4,        32'h0);
    reset = 1'b1; mem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req", {31'b0, mem_req}, 32'h0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_valid", {31'b0, inst_valid}, 32'h0);
    chk("reset_inst", inst, 32'h0);
    chk("reset_pc", inst_pc, 32'h0);
    chk("reset_err", {31'b0, misalign_err}, 32'h0);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      reset = tbl[i].in[3]; mem_ack = tbl[i].in[2]; inst_ready = tbl[i].in[1];
      redirect = tbl[i].in[0]; redirect_pc = tbl[i].rpc;
      mem_rdata = mem_ack ? f(mem_addr) : 32'hDEAD_BEEF;
      #1;
      chk($sformatf("t%0d_req", i), {31'b0, mem_req}, {31'b0, tbl[i].out[3]});
      chk($sformatf("t%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("t%0d_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].out[2]});
      chk($sformatf("t%0d_err", i), {31'b0, misalign_err}, {31'b0, tbl[i].out[1]});
      if (tbl[i].out[0]) begin
        chk($sformatf("t%0d_pc", i), inst_pc, tbl[i].pc);
        chk($sformatf("t%0d_inst", i), inst, tbl[i].out[2] ? f(tbl[i].pc) : 32'h0);
      end
    end
    // Randomized run: the model tracks delivered PCs as a queue and the stale request, if any.
    @(negedge clk);
    reset = 1'b1; mem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    q.delete(); next_fetch = 32'h0; stale = 1'b0; prev_pend = 1'b0; miss = 1'b0;
    stale_addr = '0; rb = 3; ab = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        rb = int'($urandom % 5);
        ab = int'($urandom % 3);
      end
      #1;
      exp_req  = (q.size() < DEPTH) || prev_pend || stale;
      exp_addr = stale ? stale_addr : next_fetch;
      chk("rnd_req", {31'b0, mem_req}, {31'b0, exp_req});
      chk("rnd_addr", mem_addr, exp_addr);
      chk("rnd_valid", {31'b0, inst_valid}, {31'b0, q.size() != 0});
      chk("rnd_err", {31'b0, misalign_err}, {31'b0, miss});
      if (q.size() != 0) begin
        chk("rnd_pc", inst_pc, q[0]);
        chk("rnd_inst", inst, f(q[0]));
      end
      a = mem_req && (ab == 0 || ($urandom % 3) < 32'(ab));
      r = ($urandom % 4) < 32'(rb);
      d = ($urandom % 10) == 0;
      tgt = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      mem_ack = a; inst_ready = r; redirect = d; redirect_pc = tgt;
      mem_rdata = a ? f(mem_addr) : $urandom;
      if (r && q.size() != 0) void'(q.pop_front());
      if (d) begin
        q.delete();
        next_fetch = {tgt[31:2], 2'b00};
        miss = miss | (tgt[1:0] != 2'b00);
        stale_addr = exp_addr;
        stale = exp_req && !a;
      end else if (a && stale) begin
        stale = 1'b0;
      end else if (a) begin
        q.push_back(exp_addr);
        next_fetch = next_fetch + 32'd4;
      end
      prev_pend = exp_req && !a;
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Instruction fetch front end that sits directly upstream of the processor's decode/execute datapath. It replaces the direct PC-to-instruction-memory path with a request/acknowledge memory port and buffers fetched instructions in a small FIFO. Each instruction is handed to decode together with its PC over a valid/ready handshake. Branch and jump redirects flush the FIFO and discard any in-flight stale fetch.

## Interface
Parameters:
- DEPTH, 4: FIFO entries (power of two, ≥2); each entry holds {pc[31:0], inst[31:0]}
- RESET_PC, 32'h0000_0000: first fetch address after reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- mem_req  out  1  fetch request; once high, held high with stable mem_addr until mem_ack
- mem_addr  out  32  word-aligned fetch address, [1:0] always 00
- mem_ack  in  1  request accepted and mem_rdata valid this cycle (sampled at edge while mem_req=1)
- mem_rdata  in  32  instruction word, valid only with mem_ack
- inst_valid  out  1  FIFO head valid
- inst  out  32  head instruction
- inst_pc  out  32  head PC
- inst_ready  in  1  decode consumes head when inst_valid & inst_ready
- redirect  in  1  branch/jump taken; one-cycle pulse, may repeat back-to-back
- redirect_pc  in  32  new fetch target
- misalign_err  out  1  sticky: a redirect_pc with [1:0]≠00 was seen

## Operation
- State: fetch_pc (32), FIFO (DEPTH entries, rd/wr pointers, count 0..DEPTH), FSM {FETCH, DRAIN}, misalign_err.
- FETCH: mem_req = (count < DEPTH) or a request already outstanding; mem_addr = fetch_pc.
- Ack in FETCH, no redirect: push {fetch_pc, mem_rdata}; fetch_pc += 4 (mod 2^32, wraps FFFF_FFFC→0).
- Pop: inst_valid & inst_ready advances rd pointer. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority): count←0, pointers←0, fetch_pc←{redirect_pc[31:2],2'b00}, misalign_err set if redirect_pc[1:0]≠00. A pop in the redirect cycle still completes. A push in the redirect cycle is dropped.
  - mem_req=1 & mem_ack=0 that cycle → DRAIN (stale request cannot be aborted).
  - Otherwise → FETCH; new target requested next cycle.
- DRAIN: mem_req=1 with the stale address unchanged; no push. On mem_ack the data is discarded → FETCH. A redirect during DRAIN updates fetch_pc only and stays in DRAIN (or leaves it if mem_ack is also high).
- FIFO never overflows: no request is issued at count=DEPTH, and count cannot rise while waiting.
- inst_valid = (count≠0); inst/inst_pc come from storage (registered, no mem_rdata bypass).

## Timing
- Reset values: mem_req=0 during the reset cycle, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, misalign_err=0, FSM=FETCH, count=0. Reset mid-request drops the outstanding request with no drain.
- First cycle after reset deasserts: mem_req=1, mem_addr=RESET_PC.
- Fetch-to-decode latency: ack at edge N → inst_valid=1 in cycle N+1.
- Zero-wait memory (ack whenever req): mem_req stays high, one instruction per cycle, addresses advance +4 every cycle.
- Redirect at edge R: inst_valid=0 in R+1. Without a stale request, mem_addr=redirect target in R+1. In DRAIN with stale ack at edge D, the target is requested in D+1.
- Full FIFO with no pop: mem_req low the cycle after the DEPTHth push; a pop raises mem_req the next cycle.

## Test plan
- Reset, zero-wait memory, inst_ready=1: PCs 0,4,8,… delivered one per cycle; first inst_valid 2 cycles after reset release; inst matches mem_rdata per address.
- inst_ready=0, DEPTH=4: exactly 4 pushes (PCs 0–C), then mem_req=0 with no fifth fetch. One pop → mem_req=1 at addr 0x10 next cycle; FIFO order preserved.
- 3-cycle ack latency, redirect to 0x100 in the second wait cycle: mem_addr held at the old address until ack, that data is not delivered, then fetch of 0x100; the first delivered inst_pc is 0x100.
- Redirect in the same cycle as mem_ack and as a pop: popped entry consumed, ack data dropped, FIFO empty next cycle, mem_addr=target.
- Redirect to 0x202: fetch at 0x200, misalign_err=1 and stays 1 until reset. fetch_pc at FFFF_FFFC wraps to 0000_0000.
- Reset asserted while in DRAIN: all outputs at reset values next cycle; fetch restarts at RESET_PC.
